// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and defaults for the fetch-stage PC sequencer.
// Holds the reset PC, address width, redirect-source and FSM state encodings.
package pc_ctrl_pkg;

    localparam int          PC_W_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_EXC,
        SRC_JR,
        SRC_J,
        SRC_BR
    } redir_src_e;

    typedef enum logic {
        RUN,
        PEND
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch request port: valid/ready handshake plus address.
// master = fetch controller, slave = instruction memory.
interface pc_fetch_ctrl_if #(
    parameter int PC_W = 32
);
    logic            if_req_valid;
    logic [PC_W-1:0] if_req_addr;
    logic            if_req_ready;

    modport master (
        output if_req_valid,
        output if_req_addr,
        input  if_req_ready
    );

    modport slave (
        input  if_req_valid,
        input  if_req_addr,
        output if_req_ready
    );
endinterface

// File: rtl/pc_redirect_sel.sv
// Combinational priority encoder for redirect requests: exc > jr > j/jal > branch.
// Zero latency; no state, no backpressure.
module pc_redirect_sel
    import pc_ctrl_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            exc_valid,
    input  logic [PC_W-1:0] exc_pc,
    input  logic            jrM,
    input  logic [PC_W-1:0] srca2M,
    input  logic            jumpM,
    input  logic            jalM,
    input  logic [PC_W-1:0] next_jump,
    input  logic            pcsrcM,
    input  logic [PC_W-1:0] pcbranchM,
    output logic            redir,
    output redir_src_e      src,
    output logic [PC_W-1:0] target
);

    always_comb begin
        src    = SRC_NONE;
        target = '0;
        if (exc_valid) begin
            src    = SRC_EXC;
            target = exc_pc;
        end else if (jrM) begin
            src    = SRC_JR;
            target = srca2M;
        end else if (jumpM || jalM) begin
            src    = SRC_J;
            target = next_jump;
        end else if (pcsrcM) begin
            src    = SRC_BR;
            target = pcbranchM;
        end
    end

    assign redir = (src != SRC_NONE);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC register, fetch-request handshake and redirect/flush sequencing.
// Redirect reaches if_req_addr 1 cycle later (PEND: 1 cycle after the stalled request is accepted).
// A presented request holds valid/address until accepted; redirects wait in PEND meanwhile.
// Optional macro DELAY_SLOT_EN: non-exception redirects leave flushE low.
module pc_fetch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          PC_W     = PC_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              stallF,
    input  logic              exc_valid,
    input  logic [PC_W-1:0]   exc_pc,
    input  logic              jrM,
    input  logic [PC_W-1:0]   srca2M,
    input  logic              jumpM,
    input  logic              jalM,
    input  logic [PC_W-1:0]   next_jump,
    input  logic              pcsrcM,
    input  logic [PC_W-1:0]   pcbranchM,
    pc_fetch_ctrl_if.master   imem,
    output logic [PC_W-1:0]   pcF,
    output logic [PC_W-1:0]   pcplus4F,
    output logic              flush_fetch,
    output logic              flushD,
    output logic              flushE
);

    localparam logic [PC_W-1:0] PC_INC   = PC_W'(4);
    localparam logic [PC_W-1:0] PC_RESET = PC_W'(RESET_PC);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pend_pc_q, pend_pc_d;
    logic            pend_valid_q, pend_valid_d;
    logic            req_hold_q, req_hold_d;

    logic            redir;
    redir_src_e      src;
    logic [PC_W-1:0] target;
    logic            is_exc;
    logic            req_valid;
    logic            accept;
    logic            ff_raw, fd_raw, fe_raw;

    pc_redirect_sel #(.PC_W(PC_W)) u_sel (
        .exc_valid (exc_valid),
        .exc_pc    (exc_pc),
        .jrM       (jrM),
        .srca2M    (srca2M),
        .jumpM     (jumpM),
        .jalM      (jalM),
        .next_jump (next_jump),
        .pcsrcM    (pcsrcM),
        .pcbranchM (pcbranchM),
        .redir     (redir),
        .src       (src),
        .target    (target)
    );

    assign is_exc    = (src == SRC_EXC);
    assign req_valid = resetn & (req_hold_q | ~stallF);
    assign accept    = req_valid & imem.if_req_ready;

    assign imem.if_req_valid = req_valid;
    assign imem.if_req_addr  = pc_q;
    assign pcF               = pc_q;
    assign pcplus4F          = pc_q + PC_INC;

    // A presented request is committed: hold it until the memory takes it.
    always_comb begin
        req_hold_d = req_hold_q;
        if (accept) begin
            req_hold_d = 1'b0;
        end else if (req_valid) begin
            req_hold_d = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
        ff_raw       = 1'b0;
        fd_raw       = 1'b0;
        fe_raw       = 1'b0;
        unique case (state_q)
            RUN: begin
                if (redir) begin
                    fd_raw = 1'b1;
`ifdef DELAY_SLOT_EN
                    fe_raw = is_exc;
`else
                    fe_raw = 1'b1;
`endif
                    if (accept || !req_valid) begin
                        pc_d   = target;
                        ff_raw = accept;
                    end else begin
                        pend_pc_d    = target;
                        pend_valid_d = 1'b1;
                        state_d      = PEND;
                    end
                end else if (accept) begin
                    pc_d = pc_q + PC_INC;
                end
            end
            PEND: begin
                // Only exceptions matter here; other redirects come from flushed wrong-path code.
                if (is_exc) begin
                    pend_pc_d = target;
                    fd_raw    = 1'b1;
                    fe_raw    = 1'b1;
                end
                if (accept) begin
                    pc_d         = is_exc ? target : pend_pc_q;
                    ff_raw       = 1'b1;
                    pend_valid_d = 1'b0;
                    state_d      = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign flush_fetch = resetn & ff_raw;
    assign flushD      = resetn & fd_raw;
    assign flushE      = resetn & fe_raw;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= RUN;
            pc_q         <= PC_RESET;
            pend_pc_q    <= '0;
            pend_valid_q <= 1'b0;
            req_hold_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
            req_hold_q   <= req_hold_d;
        end
    end

endmodule
